memc_arb: RTL and testbench
===========================

Name: memc_arb

Overview:
- Two-port arbiter that shares the single memc command interface between requester A (CPU bus) and requester B (loader/DMA).
- Sits between the requesters and memc; generates memc_rd_enable/memc_wr_enable pulses and returns read data and completion acks.
- Holds off all traffic while memc reports busy, including during memc's power-up BIST.

Parameters:
- DATA_WIDTH, 8, data bus width; must match memc.
- ADDR_WIDTH, 16, address bus width; must match memc.
- RD_LATENCY, 3, cycles from the memc command pulse to valid memc_rd_data; legal range 1..15; also used as the write completion delay.

Ports:
- arb_clk  in  1  clock; same clock as memc_clk.
- arb_reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; held high until a_ack.
- a_wr  in  1  port A direction: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A address.
- a_wr_data  in  DATA_WIDTH  port A write data.
- a_rd_data  out  DATA_WIDTH  port A read data, registered.
- a_ack  out  1  port A one-cycle completion pulse.
- b_req, b_wr, b_addr, b_wr_data, b_rd_data, b_ack  as port A, for port B.
- arb_grant  out  2  one-hot current owner: bit0 = A, bit1 = B; 00 when idle.
- memc_rd_enable  out  1  read command pulse to memc.
- memc_wr_enable  out  1  write command pulse to memc.
- memc_addr  out  ADDR_WIDTH  command address.
- memc_wr_data  out  DATA_WIDTH  command write data.
- memc_rd_data  in  DATA_WIDTH  read data from memc.
- memc_busy  in  1  memc not accepting commands.

Behaviour:
- Reset: all outputs are registered and clear to 0 asynchronously. State = IDLE. Last-grant pointer = B, so A wins the first tie.
- Reset mid-transaction: the transaction is dropped, no ack is issued, and rd_data clears to 0.
- States (one-hot): IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If memc_busy = 0 and any req is high, select a winner, latch its wr/addr/wr_data, set arb_grant, and go to ISSUE.
  - Otherwise stay in IDLE.
  - memc_busy = 1 blocks all issue. BIST or memc ERROR therefore stalls requesters indefinitely, with no timeout.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: round-robin; the port not granted last wins.
  - The last-grant pointer updates on each grant.
- ISSUE (one cycle):
  - Exactly one of memc_rd_enable or memc_wr_enable is high.
  - memc_addr and memc_wr_data are driven from the latched values.
  - Load counter = RD_LATENCY - 1, then go to WAIT.
  - The enables are 0 in every other state.
  - memc_addr and memc_wr_data hold their last value outside ISSUE.
- WAIT:
  - Decrement the counter each cycle; memc_busy is ignored.
  - At count 0:
    - Read: capture memc_rd_data into the winner's rd_data register.
    - Write: no capture.
  - Go to DONE.
- DONE (one cycle):
  - The winner's ack is high for exactly this cycle; its rd_data is valid and held until that port's next read completes.
  - Clear arb_grant and go to IDLE.
- Latency: a request seen in IDLE at cycle T0 (memc idle) produces an ack in cycle T0 + RD_LATENCY + 2. With the default of 3, that is T0+5.
- Throughput: one transaction per RD_LATENCY + 3 cycles.
- Requester rules:
  - Requester signals are sampled only in IDLE. Changes after the latch have no effect on the transaction.
  - A req that is still high in the cycle after ack is treated as a new request (back-to-back).
  - A req withdrawn before grant is never served.
  - A req withdrawn after the latch still completes and still acks.
- Simultaneous events:
  - A port requesting during the other port's DONE is arbitrated in the following IDLE cycle, using the updated pointer.
- Counter width: 4 bits.
- Address and data pass through unmodified; no wrap or width conversion.

Optional Feature:
- Macro: MEMC_ARB_FIXED_PRIO_EN.
- Defined: port A always wins when both request; the last-grant pointer is unused, and B can starve.
- Undefined: round-robin as in Behaviour.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Reset held low, then released with memc_busy = 1 for 20 cycles while a_req = 1 -> no memc enable pulse and no ack. memc_busy drops at cycle C -> memc_rd_enable pulses once in C+1.
- A read of addr 0x1234 with memc_rd_data = 0x5A at the capture cycle -> memc_rd_enable high for 1 cycle with memc_addr = 0x1234; a_ack in T0+5; a_rd_data = 0x5A held afterwards; b_ack stays 0.
- B write of addr 0x00FF, data 0xA5 -> memc_wr_enable for 1 cycle with addr 0x00FF and data 0xA5; b_ack in T0+5; b_rd_data unchanged.
- a_req and b_req both held high for 4 transactions -> grant order A, B, A, B. With MEMC_ARB_FIXED_PRIO_EN defined -> A, A, A, A.
- arb_reset pulsed low during WAIT -> outputs go to 0 immediately, no ack, state IDLE. After release, A wins the first tie.
- a_req dropped in the cycle after ISSUE -> transaction still completes and a_ack still pulses once.

Source files
------------

// File: rtl/memc_arb.sv
// memc_arb: shares the single memc command interface between requester A
// (CPU bus) and requester B (loader/DMA).
//
// Per transaction, the block grants one requester and drives a single-cycle
// memc_rd_enable or memc_wr_enable command pulse. It waits RD_LATENCY cycles,
// captures read data into the winner's rd_data register, then pulses the
// winner's ack. Nothing is issued while memc_busy is high.
//
// Ports:
//   arb_clk, arb_reset             clock, async active-low reset
//   a_req/a_wr/a_addr/a_wr_data    port A request (held until a_ack)
//   a_rd_data, a_ack               port A registered read data, ack pulse
//   b_*                            same for port B
//   arb_grant                      one-hot owner (bit0 = A, bit1 = B)
//   memc_rd_enable/memc_wr_enable  command pulses to memc
//   memc_addr, memc_wr_data        command address/data (held outside ISSUE)
//   memc_rd_data, memc_busy        from memc
//
// Build option: MEMC_ARB_FIXED_PRIO_EN gives port A fixed priority over B
// (B can starve). When it is undefined, ties are resolved round-robin.
module memc_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 3
) (
  input  logic                  arb_clk,
  input  logic                  arb_reset,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  b_ack,
  output logic [1:0]            arb_grant,
  output logic                  memc_rd_enable,
  output logic                  memc_wr_enable,
  output logic [ADDR_WIDTH-1:0] memc_addr,
  output logic [DATA_WIDTH-1:0] memc_wr_data,
  input  logic [DATA_WIDTH-1:0] memc_rd_data,
  input  logic                  memc_busy
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  lat_wr;
  logic                  latch;     // grant taken this cycle
  logic                  fin;       // last WAIT cycle: capture + ack next
  logic                  pick_b;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

`ifdef MEMC_ARB_FIXED_PRIO_EN
  assign pick_b = b_req && !a_req;
`else
  // last_b = 1 means B had the previous grant; resets to B so A wins the
  // first tie.
  logic last_b;
  always_ff @(posedge arb_clk or negedge arb_reset)
    if (!arb_reset)  last_b <= 1'b1;
    else if (latch)  last_b <= pick_b;

  assign pick_b = b_req && (!a_req || !last_b);
`endif

  assign sel_wr   = pick_b ? b_wr      : a_wr;
  assign sel_addr = pick_b ? b_addr    : a_addr;
  assign sel_data = pick_b ? b_wr_data : a_wr_data;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: if (!memc_busy && (a_req || b_req)) begin
        latch     = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      // memc_busy is deliberately ignored once the command has been issued.
      WAIT: if (cnt == 4'd0) begin
        fin       = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs are registered, so each one is loaded on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge arb_clk or negedge arb_reset) begin
    if (!arb_reset) begin
      state          <= IDLE;
      cnt            <= '0;
      lat_wr         <= 1'b0;
      arb_grant      <= '0;
      memc_rd_enable <= 1'b0;
      memc_wr_enable <= 1'b0;
      memc_addr      <= '0;
      memc_wr_data   <= '0;
      a_rd_data      <= '0;
      b_rd_data      <= '0;
      a_ack          <= 1'b0;
      b_ack          <= 1'b0;
    end else begin
      state          <= state_nxt;
      memc_rd_enable <= latch && !sel_wr;
      memc_wr_enable <= latch &&  sel_wr;
      a_ack          <= fin && arb_grant[0];
      b_ack          <= fin && arb_grant[1];

      if (latch) begin
        arb_grant    <= pick_b ? 2'b10 : 2'b01;
        lat_wr       <= sel_wr;
        memc_addr    <= sel_addr;
        memc_wr_data <= sel_data;
      end else if (state == DONE) begin
        arb_grant    <= '0;
      end

      if (state == ISSUE)                 cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 0) cnt <= cnt - 4'd1;

      if (fin && !lat_wr) begin
        if (arb_grant[0]) a_rd_data <= memc_rd_data;
        if (arb_grant[1]) b_rd_data <= memc_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_memc_arb.sv
// Directed bench for memc_arb (default parameters, RD_LATENCY = 3).
// A small memc model returns rd_val exactly RD_LATENCY cycles after a read
// pulse and 0xEE otherwise, so a mistimed capture is visible.
module tb_memc_arb;

  logic        clk = 1'b0;
  logic        arb_reset;
  logic        a_req, a_wr, b_req, b_wr;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wr_data, b_wr_data;
  logic [7:0]  a_rd_data, b_rd_data;
  logic        a_ack, b_ack;
  logic [1:0]  arb_grant;
  logic        memc_rd_enable, memc_wr_enable;
  logic [15:0] memc_addr;
  logic [7:0]  memc_wr_data, memc_rd_data;
  logic        memc_busy;

  logic [7:0]  rd_val;
  logic [2:0]  rd_pipe;
  int          n_chk = 0;
  int          n_fail = 0;
  int          n;

  always #5 clk = ~clk;

  memc_arb u_dut (
    .arb_clk(clk), .arb_reset(arb_reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data), .a_ack(a_ack),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wr_data(b_wr_data),
    .b_rd_data(b_rd_data), .b_ack(b_ack),
    .arb_grant(arb_grant),
    .memc_rd_enable(memc_rd_enable), .memc_wr_enable(memc_wr_enable),
    .memc_addr(memc_addr), .memc_wr_data(memc_wr_data),
    .memc_rd_data(memc_rd_data), .memc_busy(memc_busy)
  );

  always @(posedge clk) rd_pipe <= {rd_pipe[1:0], memc_rd_enable};
  assign memc_rd_data = rd_pipe[2] ? rd_val : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [1:0] exp_g;

  initial begin
    rd_pipe   = '0;
    arb_reset = 1'b0;
    memc_busy = 1'b1;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h1234; a_wr_data = 8'h00;
    b_req = 1'b0; b_wr = 1'b0; b_addr = 16'h0000; b_wr_data = 8'h00;
    rd_val = 8'h5A;

    // reset state
    repeat (3) tick;
    chk("rst_grant", arb_grant, 0);
    chk("rst_rd_en", memc_rd_enable, 0);
    chk("rst_wr_en", memc_wr_enable, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_a_rd_data", a_rd_data, 0);
    chk("rst_memc_addr", memc_addr, 0);

    // busy stalls everything
    arb_reset = 1'b1;
    n = 0;
    repeat (20) begin
      tick;
      if (memc_rd_enable || memc_wr_enable || a_ack || b_ack) n++;
    end
    chk("busy_stall", n, 0);

    // busy drops in cycle C -> read pulse in C+1, ack in C+5
    memc_busy = 1'b0;
    tick;
    chk("a_rd_en", memc_rd_enable, 1);
    chk("a_rd_wr_en", memc_wr_enable, 0);
    chk("a_rd_addr", memc_addr, 16'h1234);
    chk("a_rd_grant", arb_grant, 2'b01);
    tick;
    chk("a_rd_en_1cyc", memc_rd_enable, 0);
    tick; tick;
    chk("a_ack_early", a_ack, 0);
    tick;
    chk("a_ack", a_ack, 1);
    chk("a_rd_data", a_rd_data, 8'h5A);
    chk("a_rd_b_ack", b_ack, 0);
    a_req = 1'b0;
    tick;
    chk("a_ack_1cyc", a_ack, 0);
    chk("a_grant_clr", arb_grant, 0);
    chk("a_rd_hold", a_rd_data, 8'h5A);

    // port B write
    b_req = 1'b1; b_wr = 1'b1; b_addr = 16'h00FF; b_wr_data = 8'hA5;
    tick;
    chk("b_wr_en", memc_wr_enable, 1);
    chk("b_wr_rd_en", memc_rd_enable, 0);
    chk("b_wr_addr", memc_addr, 16'h00FF);
    chk("b_wr_data", memc_wr_data, 8'hA5);
    chk("b_wr_grant", arb_grant, 2'b10);
    repeat (4) tick;
    chk("b_ack", b_ack, 1);
    chk("b_ack_a_ack", a_ack, 0);
    chk("b_rd_unchanged", b_rd_data, 0);
    b_req = 1'b0;
    tick;
    chk("a_rd_hold2", a_rd_data, 8'h5A);

    // both requesting, back-to-back reads
    a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h0010;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
`ifdef MEMC_ARB_FIXED_PRIO_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
      rd_val = 8'h30 + 8'(i);
      tick;
      chk($sformatf("tie%0d_grant", i), arb_grant, exp_g);
      chk($sformatf("tie%0d_addr", i), memc_addr, exp_g[1] ? 16'h0020 : 16'h0010);
      repeat (4) tick;
      chk($sformatf("tie%0d_ack", i), {b_ack, a_ack}, exp_g);
      chk($sformatf("tie%0d_rd", i), exp_g[1] ? b_rd_data : a_rd_data, 8'h30 + 8'(i));
      tick;
    end
    a_req = 1'b0; b_req = 1'b0;
    tick;

    // reset during WAIT
    a_req = 1'b1; a_addr = 16'h0040; rd_val = 8'h99;
    tick; tick;
    arb_reset = 1'b0; a_req = 1'b0;
    #1;
    chk("mid_rst_grant", arb_grant, 0);
    chk("mid_rst_a_rd", a_rd_data, 0);
    chk("mid_rst_addr", memc_addr, 0);
    tick;
    arb_reset = 1'b1;
    n = 0;
    repeat (6) begin
      tick;
      if (a_ack || b_ack || memc_rd_enable || memc_wr_enable) n++;
    end
    chk("mid_rst_no_ack", n, 0);
    a_req = 1'b1; a_addr = 16'h0041; b_req = 1'b1; b_wr = 1'b0; rd_val = 8'h66;
    tick;
    chk("post_rst_tie_grant", arb_grant, 2'b01);
    repeat (4) tick;
    chk("post_rst_a_ack", a_ack, 1);
    chk("post_rst_a_rd", a_rd_data, 8'h66);
    a_req = 1'b0; b_req = 1'b0;
    tick;

    // request withdrawn after the latch still completes once
    a_req = 1'b1; a_addr = 16'h0055; rd_val = 8'h77;
    tick; tick;
    a_req = 1'b0;
    n = 0;
    repeat (8) begin
      tick;
      if (a_ack) n++;
    end
    chk("withdraw_ack_once", n, 1);
    chk("withdraw_rd", a_rd_data, 8'h77);
    chk("withdraw_idle_grant", arb_grant, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
